// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//   Turns single-beat requests from a local requester into AXI4-Lite
//   transactions. Only one transaction is in flight at a time. Its result
//   comes back on a valid/ready response port. A per-phase watchdog stops a
//   hung slave from blocking the requester forever.
//
// Ports
//   aclk, areset       clock (rising edge) and asynchronous active-high reset
//   cmd_*              command in: valid/ready, write flag, address, wdata, wstrb
//   rsp_*              response out: valid/ready, rdata, resp, timeout flag
//   aw*/w*/b*          AXI4-Lite write address, write data and write response
//   ar*/r*             AXI4-Lite read address and read data
//
// Parameters
//   ADDR_W, DATA_W     address and data widths (strobe width is DATA_W/8)
//   PROT               constant driven on awprot_out/arprot_out
//   TIMEOUT_CYCLES     maximum number of cycles per AXI phase; 0 disables the watchdog
module axi4_lite_master #(
   parameter int         ADDR_W         = 32,
   parameter int         DATA_W         = 32,
   parameter logic [2:0] PROT           = 3'b000,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                cmd_valid_in,
   output logic                cmd_ready_out,
   input  logic                cmd_write_in,
   input  logic [ADDR_W-1:0]   cmd_addr_in,
   input  logic [DATA_W-1:0]   cmd_wdata_in,
   input  logic [DATA_W/8-1:0] cmd_wstrb_in,
   output logic                rsp_valid_out,
   input  logic                rsp_ready_in,
   output logic [DATA_W-1:0]   rsp_rdata_out,
   output logic [1:0]          rsp_resp_out,
   output logic                rsp_timeout_out,
   output logic [ADDR_W-1:0]   awaddr_out,
   output logic [2:0]          awprot_out,
   output logic                awvalid_out,
   input  logic                awready_in,
   output logic [DATA_W-1:0]   wdata_out,
   output logic [DATA_W/8-1:0] wstrb_out,
   output logic                wvalid_out,
   input  logic                wready_in,
   input  logic [1:0]          bresp_in,
   input  logic                bvalid_in,
   output logic                bready_out,
   output logic [ADDR_W-1:0]   araddr_out,
   output logic [2:0]          arprot_out,
   output logic                arvalid_out,
   input  logic                arready_in,
   input  logic [DATA_W-1:0]   rdata_in,
   input  logic [1:0]          rresp_in,
   input  logic                rvalid_in,
   output logic                rready_out
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // When the watchdog is disabled this value is never used.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 0);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   logic [2:0]        state_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [STRB_W-1:0] wstrb_reg;

   logic cmd_hs, rsp_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_clear, w_clear;
   logic in_phase, phase_done, expired;

   assign cmd_hs = cmd_valid_in && cmd_ready_out;
   assign rsp_hs = rsp_valid_out && rsp_ready_in;
   assign aw_hs  = awvalid_out && awready_in;
   assign w_hs   = wvalid_out && wready_in;
   assign b_hs   = bvalid_in && bready_out;
   assign ar_hs  = arvalid_out && arready_in;
   assign r_hs   = rvalid_in && rready_out;

   // In WR_REQ, a channel whose valid is already low has finished its handshake.
   assign aw_clear = !awvalid_out || aw_hs;
   assign w_clear  = !wvalid_out || w_hs;

   always_comb begin
      in_phase   = 1'b0;
      phase_done = 1'b0;
      case (state_reg)
         S_WR_REQ:  begin in_phase = 1'b1; phase_done = aw_clear && w_clear; end
         S_WR_RESP: begin in_phase = 1'b1; phase_done = b_hs;                end
         S_RD_REQ:  begin in_phase = 1'b1; phase_done = ar_hs;               end
         S_RD_DATA: begin in_phase = 1'b1; phase_done = r_hs;                end
         default:   begin in_phase = 1'b0; phase_done = 1'b0;                end
      endcase
   end

   assign expired = WDOG_EN && (count_reg == CNT_LAST);

   assign awaddr_out = addr_reg;
   assign araddr_out = addr_reg;
   assign wdata_out  = wdata_reg;
   assign wstrb_out  = wstrb_reg;
   assign awprot_out = PROT;
   assign arprot_out = PROT;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_reg       <= S_IDLE;
         count_reg       <= '0;
         addr_reg        <= '0;
         wdata_reg       <= '0;
         wstrb_reg       <= '0;
         cmd_ready_out   <= 1'b0;
         rsp_valid_out   <= 1'b0;
         rsp_rdata_out   <= '0;
         rsp_resp_out    <= 2'b00;
         rsp_timeout_out <= 1'b0;
         awvalid_out     <= 1'b0;
         wvalid_out      <= 1'b0;
         bready_out      <= 1'b0;
         arvalid_out     <= 1'b0;
         rready_out      <= 1'b0;
      end else if (in_phase && !phase_done && expired) begin
         // Watchdog expiry: abandon the transaction and report SLVERR with
         // the timeout flag. A handshake on this edge has already set
         // phase_done and takes priority.
         awvalid_out     <= 1'b0;
         wvalid_out      <= 1'b0;
         bready_out      <= 1'b0;
         arvalid_out     <= 1'b0;
         rready_out      <= 1'b0;
         rsp_valid_out   <= 1'b1;
         rsp_rdata_out   <= '0;
         rsp_resp_out    <= 2'b10;
         rsp_timeout_out <= 1'b1;
         state_reg       <= S_RSP;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_hs) begin
                  addr_reg      <= cmd_addr_in;
                  wdata_reg     <= cmd_wdata_in;
                  wstrb_reg     <= cmd_wstrb_in;
                  cmd_ready_out <= 1'b0;
                  count_reg     <= '0;
                  if (cmd_write_in) begin
                     awvalid_out <= 1'b1;
                     wvalid_out  <= 1'b1;
                     state_reg   <= S_WR_REQ;
                  end else begin
                     arvalid_out <= 1'b1;
                     state_reg   <= S_RD_REQ;
                  end
               end else begin
                  // This branch also raises ready on the first edge after reset.
                  cmd_ready_out <= 1'b1;
               end
            end
            S_WR_REQ: begin
               if (aw_hs) awvalid_out <= 1'b0;
               if (w_hs)  wvalid_out  <= 1'b0;
               if (phase_done) begin
                  bready_out <= 1'b1;
                  count_reg  <= '0;
                  state_reg  <= S_WR_RESP;
               end else begin
                  count_reg <= count_reg + CNT_W'(1);
               end
            end
            S_WR_RESP: begin
               if (b_hs) begin
                  bready_out      <= 1'b0;
                  rsp_valid_out   <= 1'b1;
                  rsp_rdata_out   <= '0;
                  rsp_resp_out    <= bresp_in;
                  rsp_timeout_out <= 1'b0;
                  state_reg       <= S_RSP;
               end else begin
                  count_reg <= count_reg + CNT_W'(1);
               end
            end
            S_RD_REQ: begin
               if (ar_hs) begin
                  arvalid_out <= 1'b0;
                  rready_out  <= 1'b1;
                  count_reg   <= '0;
                  state_reg   <= S_RD_DATA;
               end else begin
                  count_reg <= count_reg + CNT_W'(1);
               end
            end
            S_RD_DATA: begin
               if (r_hs) begin
                  rready_out      <= 1'b0;
                  rsp_valid_out   <= 1'b1;
                  rsp_rdata_out   <= rdata_in;
                  rsp_resp_out    <= rresp_in;
                  rsp_timeout_out <= 1'b0;
                  state_reg       <= S_RSP;
               end else begin
                  count_reg <= count_reg + CNT_W'(1);
               end
            end
            S_RSP: begin
               if (rsp_hs) begin
                  rsp_valid_out <= 1'b0;
                  cmd_ready_out <= 1'b1;
                  state_reg     <= S_IDLE;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule
